// File: rtl/phase_frame_assembler.sv
// Gathers one sample per phase in any arrival order, then replays the frame in
// ascending phase order with last on the final beat; flags malformed frames.
module phase_frame_assembler #(
    parameter int N_PHASES       = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int DEST_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_phases_in_data,
    input  logic [DEST_WIDTH-1:0] i_phases_in_dest,
    input  logic                  i_phases_in_valid,
    output logic                  o_phases_in_ready,
    output logic [DATA_WIDTH-1:0] o_frame_out_data,
    output logic [DEST_WIDTH-1:0] o_frame_out_dest,
    output logic                  o_frame_out_valid,
    input  logic                  i_frame_out_ready,
    output logic                  o_frame_out_last,
    output logic                  o_err_duplicate,
    output logic                  o_err_dest,
    output logic                  o_err_timeout,
    output logic [15:0]           o_frame_count
);

    localparam int IDX_W = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [TMR_W-1:0]      TMO_LIMIT  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0]      TMR_ZERO   = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0]      TMR_ONE    = TMR_W'(1);
    localparam logic [IDX_W-1:0]      K_ZERO     = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]      K_ONE      = IDX_W'(1);
    localparam logic [IDX_W-1:0]      K_LAST     = IDX_W'(N_PHASES - 1);
    localparam logic [N_PHASES-1:0]   MASK_ZERO  = {N_PHASES{1'b0}};
    localparam logic [N_PHASES-1:0]   MASK_FULL  = {N_PHASES{1'b1}};
    localparam logic [N_PHASES-1:0]   MASK_ONE   = {{(N_PHASES-1){1'b0}}, 1'b1};
    localparam logic [DEST_WIDTH-1:0] DEST_LIMIT = DEST_WIDTH'(N_PHASES);
    localparam logic [DEST_WIDTH-1:0] DEST_ZERO  = {DEST_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DEST_WIDTH-1:0] r_out_dest;
    logic                  r_out_last;
    logic [N_PHASES-1:0]   r_mask;
    logic [TMR_W-1:0]      r_timer;
    logic [IDX_W-1:0]      r_k;
    logic                  r_err_dup;
    logic                  r_err_dest;
    logic                  r_err_tmo;
    logic [15:0]           r_frame_count;
    logic [DATA_WIDTH-1:0] r_buf [N_PHASES];

    state_t                w_state_n;
    logic                  w_in_ready_n;
    logic                  w_out_valid_n;
    logic [DATA_WIDTH-1:0] w_out_data_n;
    logic [DEST_WIDTH-1:0] w_out_dest_n;
    logic                  w_out_last_n;
    logic [N_PHASES-1:0]   w_mask_n;
    logic [TMR_W-1:0]      w_timer_n;
    logic [IDX_W-1:0]      w_k_n;
    logic                  w_err_dup_n;
    logic                  w_err_dest_n;
    logic                  w_err_tmo_n;
    logic [15:0]           w_frame_count_n;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_beat_ok;
    logic [IDX_W-1:0]      w_idx;
    logic [N_PHASES-1:0]   w_bit;
    logic                  w_complete;
    logic                  w_timeout_hit;
    logic [IDX_W-1:0]      w_k_inc;

    // Decode of the incoming beat and the frame-level conditions it triggers.
    always_comb begin
        w_accept      = r_in_ready && i_phases_in_valid;
        w_in_range    = (i_phases_in_dest < DEST_LIMIT);
        w_beat_ok     = w_accept && w_in_range;
        w_idx         = i_phases_in_dest[IDX_W-1:0];
        w_bit         = MASK_ONE << w_idx;
        w_complete    = w_beat_ok && ((r_mask | w_bit) == MASK_FULL);
        w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_mask != MASK_ZERO) && (r_timer == TMO_LIMIT);
        w_k_inc       = r_k + K_ONE;
    end

    // Next-state and next-output logic for the collect/emit sequencer.
    always_comb begin
        w_state_n       = r_state;
        w_in_ready_n    = r_in_ready;
        w_out_valid_n   = r_out_valid;
        w_out_data_n    = r_out_data;
        w_out_dest_n    = r_out_dest;
        w_out_last_n    = r_out_last;
        w_mask_n        = r_mask;
        w_timer_n       = r_timer;
        w_k_n           = r_k;
        w_err_dup_n     = 1'b0;
        w_err_dest_n    = 1'b0;
        w_err_tmo_n     = 1'b0;
        w_frame_count_n = r_frame_count;

        case (r_state)
            ST_COLLECT: begin
                w_err_dest_n = w_accept && !w_in_range;
                if (w_complete) begin
                    // Phase 0 may be the completing beat, so bypass the buffer for it.
                    w_state_n     = ST_EMIT;
                    w_in_ready_n  = 1'b0;
                    w_out_valid_n = 1'b1;
                    w_out_data_n  = (w_idx == K_ZERO) ? i_phases_in_data : r_buf[0];
                    w_out_dest_n  = DEST_ZERO;
                    w_out_last_n  = 1'b0;
                    w_k_n         = K_ZERO;
                    w_mask_n      = r_mask | w_bit;
                end else if (w_timeout_hit) begin
                    w_err_tmo_n = 1'b1;
                    if (w_beat_ok) begin
                        w_mask_n  = w_bit;
                        w_timer_n = TMR_ONE;
                    end else begin
                        w_mask_n  = MASK_ZERO;
                        w_timer_n = TMR_ZERO;
                    end
                end else if (w_beat_ok) begin
                    w_err_dup_n = |(r_mask & w_bit);
                    w_mask_n    = r_mask | w_bit;
                    w_timer_n   = r_timer + TMR_ONE;
                end else if (r_mask != MASK_ZERO) begin
                    w_timer_n = r_timer + TMR_ONE;
                end else begin
                    w_timer_n = TMR_ZERO;
                end
            end
            ST_EMIT: begin
                if (r_out_valid && i_frame_out_ready) begin
                    if (r_k == K_LAST) begin
                        w_state_n       = ST_COLLECT;
                        w_in_ready_n    = 1'b1;
                        w_out_valid_n   = 1'b0;
                        w_out_last_n    = 1'b0;
                        w_k_n           = K_ZERO;
                        w_mask_n        = MASK_ZERO;
                        w_timer_n       = TMR_ZERO;
                        w_frame_count_n = r_frame_count + 16'd1;
                    end else begin
                        w_k_n        = w_k_inc;
                        w_out_data_n = r_buf[w_k_inc];
                        w_out_dest_n = DEST_WIDTH'(w_k_inc);
                        w_out_last_n = (w_k_inc == K_LAST);
                    end
                end else begin
                    w_k_n = r_k;
                end
            end
            default: begin
                w_state_n     = ST_COLLECT;
                w_in_ready_n  = 1'b1;
                w_out_valid_n = 1'b0;
                w_mask_n      = MASK_ZERO;
                w_timer_n     = TMR_ZERO;
                w_k_n         = K_ZERO;
            end
        endcase
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_COLLECT;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_data    <= DATA_ZERO;
            r_out_dest    <= DEST_ZERO;
            r_out_last    <= 1'b0;
            r_mask        <= MASK_ZERO;
            r_timer       <= TMR_ZERO;
            r_k           <= K_ZERO;
            r_err_dup     <= 1'b0;
            r_err_dest    <= 1'b0;
            r_err_tmo     <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_state       <= w_state_n;
            r_in_ready    <= w_in_ready_n;
            r_out_valid   <= w_out_valid_n;
            r_out_data    <= w_out_data_n;
            r_out_dest    <= w_out_dest_n;
            r_out_last    <= w_out_last_n;
            r_mask        <= w_mask_n;
            r_timer       <= w_timer_n;
            r_k           <= w_k_n;
            r_err_dup     <= w_err_dup_n;
            r_err_dest    <= w_err_dest_n;
            r_err_tmo     <= w_err_tmo_n;
            r_frame_count <= w_frame_count_n;
        end
    end

    // Sample storage; contents are don't-care until the mask marks them valid.
    always_ff @(posedge clock) begin
        if (w_beat_ok) begin
            r_buf[w_idx] <= i_phases_in_data;
        end
    end

    assign o_phases_in_ready = r_in_ready;
    assign o_frame_out_valid = r_out_valid;
    assign o_frame_out_data  = r_out_data;
    assign o_frame_out_dest  = r_out_dest;
    assign o_frame_out_last  = r_out_last;
    assign o_err_duplicate   = r_err_dup;
    assign o_err_dest        = r_err_dest;
    assign o_err_timeout     = r_err_tmo;
    assign o_frame_count     = r_frame_count;

endmodule

// File: tb/tb_phase_frame_assembler.sv
// Randomized scoreboard bench for phase_frame_assembler: a set-based frame model
// predicts emitted beats and error pulses; independent monitors compare them.
module tb_phase_frame_assembler;

    localparam int N     = 6;
    localparam int DW    = 32;
    localparam int DESTW = 8;
    localparam int TMO   = 20;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [DW-1:0]    i_phases_in_data = '0;
    logic [DESTW-1:0] i_phases_in_dest = '0;
    logic             i_phases_in_valid = 1'b0;
    logic             o_phases_in_ready;
    logic [DW-1:0]    o_frame_out_data;
    logic [DESTW-1:0] o_frame_out_dest;
    logic             o_frame_out_valid;
    logic             i_frame_out_ready = 1'b1;
    logic             o_frame_out_last;
    logic             o_err_duplicate;
    logic             o_err_dest;
    logic             o_err_timeout;
    logic [15:0]      o_frame_count;

    phase_frame_assembler #(
        .N_PHASES(N), .DATA_WIDTH(DW), .DEST_WIDTH(DESTW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .i_phases_in_data(i_phases_in_data), .i_phases_in_dest(i_phases_in_dest),
        .i_phases_in_valid(i_phases_in_valid), .o_phases_in_ready(o_phases_in_ready),
        .o_frame_out_data(o_frame_out_data), .o_frame_out_dest(o_frame_out_dest),
        .o_frame_out_valid(o_frame_out_valid), .i_frame_out_ready(i_frame_out_ready),
        .o_frame_out_last(o_frame_out_last), .o_err_duplicate(o_err_duplicate),
        .o_err_dest(o_err_dest), .o_err_timeout(o_err_timeout),
        .o_frame_count(o_frame_count)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0]    data;
        logic [DESTW-1:0] dest;
        logic             last;
        int unsigned      first_cyc;
    } beat_t;

    typedef struct {
        int          kind;
        int unsigned at;
    } err_t;

    beat_t exp_q[$];
    err_t  err_q[$];
    int    checks = 0;
    int    errors = 0;
    int    out_mode = 0;
    int    mon_frames = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a frame is the set of phases received since the first beat.
    logic [DW-1:0] got[int];
    bit            m_ready = 1'b1;
    int            m_out_seen = 0;
    int unsigned   m_first = 0;

    initial begin
        int unsigned e;
        int          d;
        bit          in_rng;
        bit          tmo;
        forever begin
            @(negedge clock);
            if (!reset) begin
                got.delete();
                m_ready    = 1'b1;
                m_out_seen = 0;
                exp_q.delete();
            end else begin
                check("in_ready", 64'(o_phases_in_ready), 64'(m_ready));
                e = cyc + 1;
                if (!m_ready) begin
                    if (o_frame_out_valid && i_frame_out_ready) begin
                        m_out_seen++;
                        if (m_out_seen == N) begin
                            m_ready = 1'b1;
                            got.delete();
                        end
                    end
                end else begin
                    d      = int'(i_phases_in_dest);
                    in_rng = i_phases_in_valid && (d < N);
                    tmo    = (got.num() != 0) && (e - m_first == TMO);
                    if (in_rng && !got.exists(d) && got.num() == N - 1) begin
                        got[d] = i_phases_in_data;
                        for (int k = 0; k < N; k++)
                            exp_q.push_back('{got[k], DESTW'(k), (k == N - 1), (k == 0) ? e : 0});
                        m_ready    = 1'b0;
                        m_out_seen = 0;
                    end else begin
                        if (tmo) begin
                            err_q.push_back('{2, e});
                            got.delete();
                        end
                        if (i_phases_in_valid && d >= N) err_q.push_back('{1, e});
                        if (in_rng) begin
                            if (got.exists(d)) err_q.push_back('{0, e});
                            if (got.num() == 0) m_first = e;
                            got[d] = i_phases_in_data;
                        end
                    end
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every handshake.
    initial begin
        bit            prev_stall = 1'b0;
        bit            prev_valid = 1'b0;
        bit            was_reset  = 1'b0;
        logic [DW+DESTW:0] prev_bundle = '0;
        beat_t         b;
        forever begin
            @(negedge clock);
            if (!reset) begin
                mon_frames = 0;
                prev_stall = 1'b0;
                prev_valid = 1'b0;
                was_reset  = 1'b1;
            end else begin
                if (was_reset) begin
                    check("post_reset_valid", 64'(o_frame_out_valid), 64'd0);
                    check("post_reset_count", 64'(o_frame_count), 64'd0);
                    was_reset = 1'b0;
                end
                if (prev_stall)
                    check("hold_stable", 64'({o_frame_out_valid, o_frame_out_last, o_frame_out_dest, o_frame_out_data}),
                          64'({1'b1, prev_bundle}));
                if (o_frame_out_valid && !prev_valid && exp_q.size() > 0 && exp_q[0].first_cyc != 0)
                    check("first_beat_latency", 64'(cyc), 64'(exp_q[0].first_cyc));
                if (o_frame_out_valid && i_frame_out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got dest %0d data 0x%0h, expected no beat", o_frame_out_dest, o_frame_out_data);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_data", 64'(o_frame_out_data), 64'(b.data));
                        check("beat_dest", 64'(o_frame_out_dest), 64'(b.dest));
                        check("beat_last", 64'(o_frame_out_last), 64'(b.last));
                        check("frame_count", 64'(o_frame_count), 64'(mon_frames));
                        if (b.last) mon_frames++;
                    end
                end
                prev_stall  = o_frame_out_valid && !i_frame_out_ready;
                prev_valid  = o_frame_out_valid;
                prev_bundle = {o_frame_out_last, o_frame_out_dest, o_frame_out_data};
            end
        end
    end

    // Error-pulse monitor: every pulse must match the next predicted event exactly.
    initial begin
        bit f[3];
        forever begin
            @(negedge clock);
            while (err_q.size() > 0 && err_q[0].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL err_missing: got no pulse, expected kind %0d at cycle %0d", err_q[0].kind, err_q[0].at);
                void'(err_q.pop_front());
            end
            f[0] = o_err_duplicate;
            f[1] = o_err_dest;
            f[2] = o_err_timeout;
            for (int k = 2; k >= 0; k--) begin
                if (f[k]) begin
                    checks++;
                    if (err_q.size() > 0 && err_q[0].at == cyc && err_q[0].kind == k) begin
                        void'(err_q.pop_front());
                    end else begin
                        errors++;
                        $display("FAIL err_pulse: got kind %0d at cycle %0d, expected %s", k, cyc,
                                 (err_q.size() > 0) ? $sformatf("kind %0d at %0d", err_q[0].kind, err_q[0].at) : "none");
                    end
                end
            end
        end
    end

    // Downstream ready: always high, fixed 1,0,0,1 pattern, or random.
    initial begin
        logic [3:0] pat = 4'b1001;
        int         pi  = 0;
        forever begin
            @(posedge clock);
            #1;
            case (out_mode)
                0: i_frame_out_ready = 1'b1;
                1: begin
                    i_frame_out_ready = pat[3 - pi];
                    pi = (pi + 1) % 4;
                end
                default: i_frame_out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send(input int d, input logic [DW-1:0] x);
        int n = 0;
        i_phases_in_valid = 1'b1;
        i_phases_in_dest  = DESTW'(d);
        i_phases_in_data  = x;
        @(negedge clock);
        while (!o_phases_in_ready && n < 300) begin
            n++;
            @(negedge clock);
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL send_wait: got ready low for %0d cycles, expected ready", n);
        end
        @(posedge clock);
        #1;
        i_phases_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() > 0 || !o_phases_in_ready) && n < 500) begin
            n++;
            idle(1);
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d beats pending after %0d cycles, expected 0", exp_q.size(), n);
        end
    endtask

    initial begin
        int order[6] = '{5, 0, 4, 1, 3, 2};
        int perm[N];
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_valid", 64'(o_frame_out_valid), 64'd0);
        check("rst_data", 64'(o_frame_out_data), 64'd0);
        check("rst_dest", 64'(o_frame_out_dest), 64'd0);
        check("rst_last", 64'(o_frame_out_last), 64'd0);
        check("rst_ready", 64'(o_phases_in_ready), 64'd1);
        check("rst_count", 64'(o_frame_count), 64'd0);
        check("rst_errs", 64'({o_err_duplicate, o_err_dest, o_err_timeout}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < N; i++) send(i, DW'(100 + i));
        wait_drain();
        check("count_after_first", 64'(o_frame_count), 64'd1);

        for (int i = 0; i < N; i++) send(order[i], DW'(order[i] * 16));
        wait_drain();

        out_mode = 1;
        for (int i = 0; i < N; i++) send(i, $urandom);
        wait_drain();
        out_mode = 0;

        send(2, 32'h11);
        send(2, 32'h22);
        send(9, 32'hdead);
        foreach (order[i]) if (order[i] != 2) send(order[i], DW'(32'h70 + order[i]));
        wait_drain();

        for (int i = 0; i < 4; i++) send(i, DW'(32'h200 + i));
        idle(30);
        for (int i = 0; i < N; i++) send(i, DW'(32'h300 + i));
        wait_drain();

        for (int i = 0; i < N; i++) send(i, DW'(32'h400 + i));
        idle(3);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < N; i++) send(N - 1 - i, DW'(32'h500 + i));
        wait_drain();
        check("count_after_reset", 64'(o_frame_count), 64'd1);

        for (int f = 0; f < 40; f++) begin
            out_mode = 2;
            for (int i = 0; i < N; i++) perm[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                int j;
                int t;
                j = $urandom_range(0, i);
                t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            for (int i = 0; i < N; i++) begin
                if (i > 0 && $urandom_range(0, 7) == 0) send(perm[i - 1], $urandom);
                if ($urandom_range(0, 9) == 0) send($urandom_range(N, 255), $urandom);
                if ($urandom_range(0, 19) == 0) idle(22);
                else if ($urandom_range(0, 4) == 0) idle(1);
                send(perm[i], $urandom);
            end
        end
        idle(30);
        wait_drain();

        check("beats_left", 64'(exp_q.size()), 64'd0);
        check("errs_left", 64'(err_q.size()), 64'd0);
        check("final_count", 64'(o_frame_count), 64'(mon_frames));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
